axis_fx_scheduler: RTL and testbench

//  Frame sequencer between the I2S RX AXIS master and the I2S TX AXIS slave (2-word packets: L then R, last on R).

---
 rtl/axis_fx_pkg.sv | 21 ++
 rtl/axis_fx_watchdog.sv | 34 +++
 rtl/axis_fx_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_axis_fx_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fx_pkg.sv
// Shared types for the AXIS effect scheduler: frame sequencer states,
// channel tags and the default sample width.
package axis_fx_pkg;

  localparam int DATA_W_DEF = 24;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  typedef enum logic [2:0] {
    RX_L   = 3'd0,
    RX_R   = 3'd1,
    ISS_L  = 3'd2,
    WAIT_L = 3'd3,
    ISS_R  = 3'd4,
    WAIT_R = 3'd5,
    TX_L   = 3'd6,
    TX_R   = 3'd7
  } state_t;

endpackage

// File: rtl/axis_fx_watchdog.sv
// Response watchdog: counts cycles while en=1, restarts on clr.
// Ports: clk, rst_n, clr, en in; expire out (current cycle is the TIMEOUT-th).
module axis_fx_watchdog #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W:0] LIM = TIMEOUT[TO_W:0];

  logic [TO_W-1:0] cnt;
  logic [TO_W:0]   cnt_nxt;

  // cnt holds the number of cycles already waited, so the
  // current cycle is number cnt+1.
  assign cnt_nxt = {1'b0, cnt} + {{TO_W{1'b0}}, 1'b1};
  assign expire  = (cnt_nxt == LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !cnt_nxt[TO_W]) begin
      cnt <= cnt_nxt[TO_W-1:0];
    end
  end

endmodule

// File: rtl/axis_fx_scheduler.sv
// Stereo frame sequencer: RX L/R -> shared mono fx core -> TX L/R,
// with bypass, mute and a response watchdog.
// Ports: axis_clk/axis_resetn; s_axis_* RX slave; m_axis_* TX master;
// fx_req_*/fx_rsp_* effect core; bypass, mute in; busy, timeout_err out.
// Optional AXIS_FX_SCHED_STATS_EN adds frame_cnt and timeout_cnt.
module axis_fx_scheduler
  import axis_fx_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              axis_clk,
  input  logic              axis_resetn,
  input  logic [31:0]       s_axis_data,
  input  logic              s_axis_valid,
  output logic              s_axis_ready,
  input  logic              s_axis_last,
  output logic [31:0]       m_axis_data,
  output logic              m_axis_valid,
  input  logic              m_axis_ready,
  output logic              m_axis_last,
  output logic [DATA_W-1:0] fx_req_data,
  output logic              fx_req_ch,
  output logic              fx_req_valid,
  input  logic              fx_req_ready,
  input  logic [DATA_W-1:0] fx_rsp_data,
  input  logic              fx_rsp_ch,
  input  logic              fx_rsp_valid,
  input  logic              bypass,
  input  logic              mute,
  output logic              busy,
  output logic              timeout_err
`ifdef AXIS_FX_SCHED_STATS_EN
  ,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       timeout_cnt
`endif
);

  state_t st, nxt;

  logic [DATA_W-1:0] l_smp, r_smp, tx_smp;
  logic              mute_q;
  logic              st_l, st_r, latch;
  logic              wet_l, wet_r;
  logic              wd_clr, wd_en, wd_exp;
  logic              rsp_l, rsp_r;
  logic              unused_hi;

  assign unused_hi = ^s_axis_data[31:DATA_W];

  assign rsp_l = fx_rsp_valid && (fx_rsp_ch == CH_L);
  assign rsp_r = fx_rsp_valid && (fx_rsp_ch == CH_R);

  axis_fx_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk    (axis_clk),
    .rst_n  (axis_resetn),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_exp)
  );

  always_comb begin
    nxt          = st;
    s_axis_ready = 1'b0;
    fx_req_valid = 1'b0;
    m_axis_valid = 1'b0;
    timeout_err  = 1'b0;
    wd_clr       = 1'b0;
    wd_en        = 1'b0;
    st_l         = 1'b0;
    st_r         = 1'b0;
    latch        = 1'b0;
    wet_l        = 1'b0;
    wet_r        = 1'b0;
    unique case (st)
      RX_L: begin
        s_axis_ready = 1'b1;
        // A lone R word means we lost sync: drop it.
        if (s_axis_valid && !s_axis_last) begin
          st_l = 1'b1;
          nxt  = RX_R;
        end
      end
      RX_R: begin
        s_axis_ready = 1'b1;
        if (s_axis_valid) begin
          if (s_axis_last) begin
            st_r  = 1'b1;
            latch = 1'b1;
            nxt   = bypass ? TX_L : ISS_L;
          end else begin
            st_l = 1'b1;
          end
        end
      end
      ISS_L: begin
        fx_req_valid = 1'b1;
        if (fx_req_ready) begin
          wd_clr = 1'b1;
          nxt    = WAIT_L;
        end
      end
      WAIT_L: begin
        wd_en = 1'b1;
        if (rsp_l) begin
          wet_l = 1'b1;
          nxt   = ISS_R;
        end else if (wd_exp) begin
          timeout_err = 1'b1;
          nxt         = ISS_R;
        end
      end
      ISS_R: begin
        fx_req_valid = 1'b1;
        if (fx_req_ready) begin
          wd_clr = 1'b1;
          nxt    = WAIT_R;
        end
      end
      WAIT_R: begin
        wd_en = 1'b1;
        if (rsp_r) begin
          wet_r = 1'b1;
          nxt   = TX_L;
        end else if (wd_exp) begin
          timeout_err = 1'b1;
          nxt         = TX_L;
        end
      end
      TX_L: begin
        m_axis_valid = 1'b1;
        if (m_axis_ready) nxt = TX_R;
      end
      TX_R: begin
        m_axis_valid = 1'b1;
        if (m_axis_ready) nxt = RX_L;
      end
    endcase
  end

  // Dry samples are overwritten in place by the wet result, so a
  // timeout simply leaves the dry value to be sent.
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      st     <= RX_L;
      l_smp  <= '0;
      r_smp  <= '0;
      mute_q <= 1'b0;
    end else begin
      st <= nxt;
      if (st_l) begin
        l_smp <= s_axis_data[DATA_W-1:0];
      end else if (wet_l) begin
        l_smp <= fx_rsp_data;
      end
      if (st_r) begin
        r_smp <= s_axis_data[DATA_W-1:0];
      end else if (wet_r) begin
        r_smp <= fx_rsp_data;
      end
      if (latch) mute_q <= mute;
    end
  end

  assign busy = (st != RX_L);

  assign fx_req_ch   = (st == ISS_R);
  assign fx_req_data = !fx_req_valid ? '0
                     : (fx_req_ch ? r_smp : l_smp);

  assign tx_smp      = (st == TX_R) ? r_smp : l_smp;
  assign m_axis_last = (st == TX_R);
  assign m_axis_data = (m_axis_valid && !mute_q)
                     ? {{(32-DATA_W){1'b0}}, tx_smp}
                     : 32'h0;

`ifdef AXIS_FX_SCHED_STATS_EN
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      frame_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      if (st == TX_R && m_axis_ready) begin
        frame_cnt <= frame_cnt + 32'd1;
      end
      if (timeout_err && timeout_cnt != 16'hFFFF) begin
        timeout_cnt <= timeout_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_fx_scheduler.sv
// Directed + randomized bench for axis_fx_scheduler with an
// echo-style fx core model and a frame-level reference model.
module tb_axis_fx_scheduler;

  localparam int DW      = 24;
  localparam int TIMEOUT = 255;
  localparam int BOUND   = 4000;

  logic          clk;
  logic          axis_resetn;
  logic [31:0]   s_axis_data;
  logic          s_axis_valid;
  logic          s_axis_ready;
  logic          s_axis_last;
  logic [31:0]   m_axis_data;
  logic          m_axis_valid;
  logic          m_axis_ready;
  logic          m_axis_last;
  logic [DW-1:0] fx_req_data;
  logic          fx_req_ch;
  logic          fx_req_valid;
  logic          fx_req_ready;
  logic [DW-1:0] fx_rsp_data;
  logic          fx_rsp_ch;
  logic          fx_rsp_valid;
  logic          bypass;
  logic          mute;
  logic          busy;
  logic          timeout_err;
`ifdef AXIS_FX_SCHED_STATS_EN
  logic [31:0]   frame_cnt;
  logic [15:0]   timeout_cnt;
`endif

  axis_fx_scheduler #(
    .DATA_W  (DW),
    .TIMEOUT (TIMEOUT),
    .TO_W    (8)
  ) dut (
    .axis_clk     (clk),
    .axis_resetn  (axis_resetn),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_last  (s_axis_last),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .fx_req_data  (fx_req_data),
    .fx_req_ch    (fx_req_ch),
    .fx_req_valid (fx_req_valid),
    .fx_req_ready (fx_req_ready),
    .fx_rsp_data  (fx_rsp_data),
    .fx_rsp_ch    (fx_rsp_ch),
    .fx_rsp_valid (fx_rsp_valid),
    .bypass       (bypass),
    .mute         (mute),
    .busy         (busy),
    .timeout_err  (timeout_err)
`ifdef AXIS_FX_SCHED_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .timeout_cnt  (timeout_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  logic [32:0] got_mem [0:511];
  int          got_n = 0;
  int          got_rd = 0;
  int          tmo_cyc [0:255];
  int          tmo_n = 0;
  int          req_n = 0;

  bit rdy_rand   = 1'b0;
  bit mrdy_force = 1'b1;
  bit core_on    = 1'b1;
  bit bad_tag    = 1'b0;
  int inj_req    = 0;

  int frame_model = 0;
  int tmo_model   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observers: TX words, watchdog pulses, fx request handshakes.
  always @(negedge clk) begin
    if (axis_resetn && m_axis_valid && m_axis_ready) begin
      got_mem[got_n] <= {m_axis_last, m_axis_data};
      got_n <= got_n + 1;
    end
    if (timeout_err) begin
      tmo_cyc[tmo_n] <= cyc;
      tmo_n <= tmo_n + 1;
    end
    if (fx_req_valid && fx_req_ready) req_n <= req_n + 1;
  end

  // Ready drivers for TX and fx request.
  initial begin
    m_axis_ready = 1'b1;
    fx_req_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_ready = rdy_rand ? 1'($urandom_range(0, 1)) : mrdy_force;
      fx_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Fx core model: answers x+1 three cycles after the request,
  // optionally preceded by a response with the wrong channel tag.
  initial begin
    bit          pend;
    int          dly;
    logic [DW-1:0] cap_d;
    logic        cap_ch;
    int          inj_done;
    pend = 1'b0;
    dly = 0;
    cap_d = '0;
    cap_ch = 1'b0;
    inj_done = 0;
    fx_rsp_valid = 1'b0;
    fx_rsp_data = '0;
    fx_rsp_ch = 1'b0;
    forever begin
      @(negedge clk);
      if (fx_req_valid && fx_req_ready && core_on) begin
        pend = 1'b1;
        dly = 3;
        cap_d = fx_req_data;
        cap_ch = fx_req_ch;
      end
      @(posedge clk);
      #1;
      fx_rsp_valid = 1'b0;
      if (inj_done != inj_req) begin
        inj_done = inj_req;
        fx_rsp_valid = 1'b1;
        fx_rsp_ch = 1'b1;
        fx_rsp_data = 24'h123456;
      end else if (pend) begin
        dly--;
        if (dly == 0) begin
          fx_rsp_valid = 1'b1;
          fx_rsp_ch = cap_ch;
          fx_rsp_data = cap_d + 24'd1;
          pend = 1'b0;
        end else if (dly == 1 && bad_tag) begin
          fx_rsp_valid = 1'b1;
          fx_rsp_ch = ~cap_ch;
          fx_rsp_data = cap_d ^ 24'h5A5A5A;
        end
      end
    end
  end

  function automatic logic [31:0] model(
    input logic [23:0] s, input bit byp, mut, fx_ok);
    if (mut) return 32'h0;
    if (!byp && fx_ok) return {8'h00, s + 24'd1};
    return {8'h00, s};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs, exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [23:0] d, input bit last,
                           input bit byp, mut);
    int n;
    @(posedge clk);
    #1;
    s_axis_data = {8'($urandom), d};
    s_axis_last = last;
    s_axis_valid = 1'b1;
    bypass = byp;
    mute = mut;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axis_ready && n < BOUND);
    chk("rx_accept", 32'(n < BOUND), 32'd1);
    @(posedge clk);
    #1;
    s_axis_valid = 1'b0;
    bypass = ~byp;
    mute = ~mut;
  endtask

  task automatic send_frame(input logic [23:0] l, r,
                            input bit byp, mut);
    send_word(l, 1'b0, ~byp, ~mut);
    send_word(r, 1'b1, byp, mut);
  endtask

  task automatic wait_words(input int k, input string tag);
    int n;
    n = 0;
    while (got_n < got_rd + k && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wait"}, 32'(n < BOUND), 32'd1);
  endtask

  task automatic check_frame(input string tag,
                             input logic [31:0] el, er);
    wait_words(2, tag);
    chk({tag, "_ldat"}, got_mem[got_rd][31:0], el);
    chk({tag, "_llast"}, 32'(got_mem[got_rd][32]), 32'd0);
    chk({tag, "_rdat"}, got_mem[got_rd+1][31:0], er);
    chk({tag, "_rlast"}, 32'(got_mem[got_rd+1][32]), 32'd1);
    got_rd = got_rd + 2;
    frame_model++;
  endtask

  task automatic do_reset();
    axis_resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    axis_resetn = 1'b1;
    frame_model = 0;
    tmo_model = 0;
  endtask

  task automatic check_stats(input string tag);
`ifdef AXIS_FX_SCHED_STATS_EN
    @(negedge clk);
    chk({tag, "_frames"}, frame_cnt, 32'(frame_model));
    chk({tag, "_tmos"}, 32'(timeout_cnt), 32'(tmo_model));
`else
    @(negedge clk);
`endif
  endtask

  initial begin
    int t0, r0, n, g0;
    bit ok;
    logic [23:0] l, r;
    bit byp, mut;
    axis_resetn = 1'b0;
    s_axis_data = '0;
    s_axis_valid = 1'b0;
    s_axis_last = 1'b0;
    bypass = 1'b0;
    mute = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_sready", 32'(s_axis_ready), 32'd1);
    chk("rst_mvalid", 32'(m_axis_valid), 32'd0);
    chk("rst_req", 32'(fx_req_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_mdata", m_axis_data, 32'd0);
    check_stats("rst");

    // 1: fx path, core echoes x+1
    send_frame(24'h000100, 24'h000200, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_sready", 32'(s_axis_ready), 32'd0);
    check_frame("t1", 32'h00000101, 32'h00000201);

    // 2: bypass, no fx request, one-cycle latency
    r0 = req_n;
    send_frame(24'h7FFFFF, 24'h800000, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_lat_v", 32'(m_axis_valid), 32'd1);
    chk("t2_lat_last", 32'(m_axis_last), 32'd0);
    check_frame("t2", 32'h007FFFFF, 32'h00800000);
    @(negedge clk);
    chk("t2_noreq", 32'(req_n - r0), 32'd0);
    chk("t2_done_v", 32'(m_axis_valid), 32'd0);

    // 3: core silent, two timeouts, dry samples out
    core_on = 1'b0;
    t0 = tmo_n;
    send_frame(24'h0ABCDE, 24'h012345, 1'b0, 1'b0);
    check_frame("t3", 32'h000ABCDE, 32'h00012345);
    chk("t3_pulses", 32'(tmo_n - t0), 32'd2);
    chk("t3_gap", 32'(tmo_cyc[t0+1] - tmo_cyc[t0]), 32'd256);
    tmo_model += 2;
    check_stats("t3");
    core_on = 1'b1;

    // 4: resync on stray R, L overwritten by L'
    send_word(24'hAAAAAA, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_drop", 32'(busy), 32'd0);
    send_word(24'h000010, 1'b0, 1'b1, 1'b1);
    send_word(24'h000020, 1'b0, 1'b1, 1'b1);
    send_word(24'h000030, 1'b1, 1'b0, 1'b0);
    check_frame("t4", 32'h00000021, 32'h00000031);

    // 5: TX stall with mute, wrong-tag responses interleaved
    bad_tag = 1'b1;
    mrdy_force = 1'b0;
    send_frame(24'h111111, 24'h222222, 1'b0, 1'b1);
    n = 0;
    while (!m_axis_valid && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_tx", 32'(m_axis_valid), 32'd1);
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!m_axis_valid || m_axis_last || m_axis_data != 32'h0)
        ok = 1'b0;
    end
    chk("t5_stable", 32'(ok), 32'd1);
    chk("t5_sready", 32'(s_axis_ready), 32'd0);
    mrdy_force = 1'b1;
    check_frame("t5", 32'h0, 32'h0);
    bad_tag = 1'b0;
    check_stats("t5");

    // 6: reset in WAIT_R, then stale R response
    core_on = 1'b0;
    send_frame(24'h333333, 24'h444444, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fx_req_valid && fx_req_ch && fx_req_ready)
               && n < BOUND);
    chk("t6_reach_iss_r", 32'(n < BOUND), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    core_on = 1'b1;
    inj_req++;
    g0 = got_n;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (m_axis_valid || busy || !s_axis_ready) ok = 1'b0;
    end
    chk("t6_idle", 32'(ok), 32'd1);
    chk("t6_no_tx", 32'(got_n - g0), 32'd0);
    got_rd = got_n;
    check_stats("t6");
    send_frame(24'h000555, 24'h000666, 1'b0, 1'b0);
    check_frame("t6_after", 32'h00000556, 32'h00000667);

    // Randomized frames against the frame-level model
    rdy_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      l = 24'($urandom);
      r = 24'($urandom);
      byp = ($urandom_range(0, 3) == 0);
      mut = ($urandom_range(0, 4) == 0);
      core_on = ($urandom_range(0, 4) != 0);
      bad_tag = 1'($urandom_range(0, 1));
      t0 = tmo_n;
      send_frame(l, r, byp, mut);
      check_frame($sformatf("rnd%0d", i),
                  model(l, byp, mut, core_on),
                  model(r, byp, mut, core_on));
      n = (!byp && !core_on) ? 2 : 0;
      chk($sformatf("rnd%0d_tmo", i), 32'(tmo_n - t0), 32'(n));
      tmo_model += n;
    end
    rdy_rand = 1'b0;
    core_on = 1'b1;
    repeat (3) @(posedge clk);
    check_stats("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
